// File: rtl/uart_rx_frame_if.sv
// Receive-side output bundle of the UART frame receiver.
// The receiver drives it through the master modport and the downstream
// command FSM reads it through the slave modport.
interface uart_rx_frame_if;
  logic [7:0] rx_data;
  logic       rx_vld;
  logic       parity_err;
  logic       frame_err;
  logic       busy;

  modport master (
    output rx_data,
    output rx_vld,
    output parity_err,
    output frame_err,
    output busy
  );

  modport slave (
    input rx_data,
    input rx_vld,
    input parity_err,
    input frame_err,
    input busy
  );
endinterface

// File: rtl/uart_rx_frame.sv
// UART receive front end.
// Deserialises one frame from the rx pin: a start bit, 8 data bits sent LSB
// first, an optional parity bit, and a stop bit. Each byte is presented with a
// one-cycle valid pulse together with parity and framing error flags.
//
// The rx line is synchronised through two flops, and a third flop provides the
// delayed copy used for falling-edge detection. Every bit, including the start
// and stop bits, is sampled at the middle count of the baud counter. The stop
// bit is sampled mid-bit and the FSM returns to IDLE at once, so a new start
// edge can follow directly after the stop bit.
module uart_rx_frame #(
  parameter int unsigned BR         = 434,  // clk cycles per bit, >= 4
  parameter int unsigned PARITY_EN  = 1,    // 1: parity bit present
  parameter int unsigned PARITY_ODD = 1     // 1: expect ~^data, 0: expect ^data
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           rx,
  uart_rx_frame_if.master rx_if
);

  localparam int unsigned BW = (BR > 1) ? $clog2(BR) : 1;
  localparam logic [BW-1:0] HALF = BW'(BR / 2);
  localparam logic [BW-1:0] LAST = BW'(BR - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  // Line conditioning
  logic          r_sync1;
  logic          r_rx_s;
  logic          r_rx_d;
  logic          w_fall;

  // FSM and counters
  state_t        r_state;
  state_t        w_state_next;
  logic [BW-1:0] r_baud;
  logic [2:0]    r_bit;
  logic          w_at_half;
  logic          w_at_last;

  // Sample strobes decoded by the FSM
  logic          w_smp_data;
  logic          w_smp_par;
  logic          w_smp_stop;

  // Frame capture
  logic [7:0]    r_shift;
  logic          r_par;
  logic          w_par_exp;
  logic          w_par_bad;

  // Output registers
  logic [7:0]    r_rx_data;
  logic          r_rx_vld;
  logic          r_parity_err;
  logic          r_frame_err;

  // Two-flop synchroniser plus one delay flop; all reset to the idle-high level
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= 1'b1;
      r_rx_s  <= 1'b1;
      r_rx_d  <= 1'b1;
    end else begin
      r_sync1 <= rx;
      r_rx_s  <= r_sync1;
      r_rx_d  <= r_rx_s;
    end
  end

  assign w_fall    = r_rx_d & ~r_rx_s;
  assign w_at_half = (r_baud == HALF);
  assign w_at_last = (r_baud == LAST);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state decode and per-state sample strobes
  always_comb begin
    w_state_next = r_state;
    w_smp_data   = 1'b0;
    w_smp_par    = 1'b0;
    w_smp_stop   = 1'b0;
    case (r_state)
      S_IDLE: begin
        // Edges are only looked for here; an edge mid-frame is ignored.
        if (w_fall) begin
          w_state_next = S_START;
        end
      end
      S_START: begin
        // A line already back high at mid start bit was a glitch.
        if (w_at_half && r_rx_s) begin
          w_state_next = S_IDLE;
        end else if (w_at_last) begin
          w_state_next = S_DATA;
        end
      end
      S_DATA: begin
        w_smp_data = w_at_half;
        if (w_at_last && (r_bit == 3'd7)) begin
          w_state_next = (PARITY_EN != 0) ? S_PARITY : S_STOP;
        end
      end
      S_PARITY: begin
        w_smp_par = w_at_half;
        if (w_at_last) begin
          w_state_next = S_STOP;
        end
      end
      S_STOP: begin
        // Leave mid stop bit so a back-to-back start edge is not missed.
        w_smp_stop = w_at_half;
        if (w_at_half) begin
          w_state_next = S_IDLE;
        end
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  // Baud counter: restarts on every state entry, wraps at BR-1, parked in IDLE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_baud <= '0;
    end else if ((w_state_next != r_state) || (r_state == S_IDLE) || w_at_last) begin
      r_baud <= '0;
    end else begin
      r_baud <= r_baud + BW'(1);
    end
  end

  // Data bit index: held at 0 outside DATA, advances at the end of each bit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bit <= 3'd0;
    end else if (r_state != S_DATA) begin
      r_bit <= 3'd0;
    end else if (w_at_last) begin
      r_bit <= r_bit + 3'd1;
    end
  end

  // Capture data bits (LSB first) and the parity bit at mid-bit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shift <= 8'h00;
      r_par   <= 1'b0;
    end else begin
      if (w_smp_data) begin
        r_shift[r_bit] <= r_rx_s;
      end
      if (w_smp_par) begin
        r_par <= r_rx_s;
      end
    end
  end

  assign w_par_exp = (PARITY_ODD != 0) ? ~^r_shift : ^r_shift;
  assign w_par_bad = (PARITY_EN != 0) ? (r_par != w_par_exp) : 1'b0;

  // Publish the frame on the cycle after the stop sample; flags hold until the next frame
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rx_data    <= 8'h00;
      r_rx_vld     <= 1'b0;
      r_parity_err <= 1'b0;
      r_frame_err  <= 1'b0;
    end else begin
      r_rx_vld <= w_smp_stop;
      if (w_smp_stop) begin
        r_rx_data    <= r_shift;
        r_frame_err  <= ~r_rx_s;
        r_parity_err <= w_par_bad;
      end
    end
  end

  assign rx_if.rx_data    = r_rx_data;
  assign rx_if.rx_vld     = r_rx_vld;
  assign rx_if.parity_err = r_parity_err;
  assign rx_if.frame_err  = r_frame_err;
  assign rx_if.busy       = (r_state != S_IDLE);

endmodule

// File: tb/tb_uart_rx_frame.sv
// Directed bench for uart_rx_frame.
// Two instances: A with parity (odd) and a short bit time, B with BR=4 and no
// parity. Expected frames are queued when their start bit is driven and are
// popped and compared whenever the matching instance pulses rx_vld.
module tb_uart_rx_frame;

  localparam int BRA   = 20;
  localparam int HALFA = BRA / 2;
  localparam int BRB   = 4;

  typedef struct {
    logic [7:0] d;
    logic       pe;
    logic       fe;
    int         t0;
    bit         lat;
  } exp_t;

  logic clk;
  logic rst_n;
  logic rxa;
  logic rxb;
  int   cyc;
  int   checks;
  int   errors;

  exp_t qa[$];
  exp_t qb[$];

  uart_rx_frame_if ifa ();
  uart_rx_frame_if ifb ();

  uart_rx_frame #(.BR(BRA), .PARITY_EN(1), .PARITY_ODD(1)) u_dut_a (
    .clk   (clk),
    .rst_n (rst_n),
    .rx    (rxa),
    .rx_if (ifa)
  );

  uart_rx_frame #(.BR(BRB), .PARITY_EN(0), .PARITY_ODD(1)) u_dut_b (
    .clk   (clk),
    .rst_n (rst_n),
    .rx    (rxb),
    .rx_if (ifb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Pops and compares one frame whenever an instance pulses rx_vld
  task automatic monitor();
    exp_t e;
    int   lat;
    forever begin
      @(negedge clk);
      if (ifa.rx_vld === 1'b1) begin
        chk("A_vld_expected", 32'(qa.size() > 0), 32'd1);
        if (qa.size() > 0) begin
          e = qa.pop_front();
          $display("A frame data=%02h perr=%0b ferr=%0b cyc=%0d",
                   ifa.rx_data, ifa.parity_err, ifa.frame_err, cyc);
          chk("A_rx_data", 32'(ifa.rx_data), 32'(e.d));
          chk("A_parity_err", 32'(ifa.parity_err), 32'(e.pe));
          chk("A_frame_err", 32'(ifa.frame_err), 32'(e.fe));
          if (e.lat) begin
            lat = cyc - e.t0;
            chk($sformatf("A_latency_%0d_in_window", lat),
                32'((lat >= 3 + 10*BRA + HALFA) && (lat <= 3 + 10*BRA + HALFA + 2)), 32'd1);
          end
        end
      end
      if (ifb.rx_vld === 1'b1) begin
        chk("B_vld_expected", 32'(qb.size() > 0), 32'd1);
        if (qb.size() > 0) begin
          e = qb.pop_front();
          $display("B frame data=%02h perr=%0b ferr=%0b cyc=%0d",
                   ifb.rx_data, ifb.parity_err, ifb.frame_err, cyc);
          chk("B_rx_data", 32'(ifb.rx_data), 32'(e.d));
          chk("B_parity_err", 32'(ifb.parity_err), 32'(e.pe));
          chk("B_frame_err", 32'(ifb.frame_err), 32'(e.fe));
        end
      end
    end
  endtask

  // Drives one bit period on the selected line; entered and left 1 unit after a posedge
  task automatic drive_bit(input bit sel, input logic v);
    if (sel) rxb = v;
    else     rxa = v;
    repeat (sel ? BRB : BRA) @(posedge clk);
    #1;
  endtask

  // Queues the expected result and drives one complete frame
  task automatic send_frame(input bit sel, input logic [7:0] d, input logic par,
                            input logic stop, input bit lat);
    exp_t e;
    e.d   = d;
    e.pe  = sel ? 1'b0 : (par != ~^d);
    e.fe  = ~stop;
    e.t0  = cyc;
    e.lat = lat;
    if (sel) qb.push_back(e);
    else     qa.push_back(e);
    drive_bit(sel, 1'b0);
    for (int i = 0; i < 8; i++) drive_bit(sel, d[i]);
    if (!sel) drive_bit(sel, par);
    drive_bit(sel, stop);
  endtask

  task automatic chk_outputs_reset(input string who);
    chk({who, "_rst_rx_data"}, 32'(ifa.rx_data), 32'h00);
    chk({who, "_rst_rx_vld"}, 32'(ifa.rx_vld), 32'd0);
    chk({who, "_rst_parity_err"}, 32'(ifa.parity_err), 32'd0);
    chk({who, "_rst_frame_err"}, 32'(ifa.frame_err), 32'd0);
    chk({who, "_rst_busy"}, 32'(ifa.busy), 32'd0);
  endtask

  initial begin
    exp_t e;
    logic [7:0] d;
    cyc    = 0;
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    rxa    = 1'b1;
    rxb    = 1'b1;
    fork
      monitor();
    join_none

    // Reset values
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_outputs_reset("A_init");
    chk("B_init_busy", 32'(ifb.busy), 32'd0);
    chk("B_init_rx_vld", 32'(ifb.rx_vld), 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (5) @(posedge clk);
    #1;

    // Good frame with latency measurement
    send_frame(1'b0, 8'hA5, 1'b1, 1'b1, 1'b1);
    drive_bit(1'b0, 1'b1);

    // Parity good, then parity bad; flag must hold afterwards
    send_frame(1'b0, 8'h3C, 1'b1, 1'b1, 1'b0);
    send_frame(1'b0, 8'h3C, 1'b0, 1'b1, 1'b0);
    repeat (2 * BRA) @(posedge clk);
    @(negedge clk);
    chk("A_parity_err_held", 32'(ifa.parity_err), 32'd1);
    chk("A_rx_data_held", 32'(ifa.rx_data), 32'h3C);
    @(posedge clk);
    #1;

    // Start-bit glitch of BR/4 cycles
    rxa = 1'b0;
    repeat (BRA / 4) @(posedge clk);
    @(negedge clk);
    chk("A_glitch_busy_high", 32'(ifa.busy), 32'd1);
    @(posedge clk);
    #1 rxa = 1'b1;
    repeat (HALFA + 4 - BRA / 4 - 1) @(posedge clk);
    @(negedge clk);
    chk("A_glitch_busy_low", 32'(ifa.busy), 32'd0);
    chk("A_glitch_parity_err", 32'(ifa.parity_err), 32'd1);
    chk("A_glitch_frame_err", 32'(ifa.frame_err), 32'd0);
    chk("A_glitch_rx_data", 32'(ifa.rx_data), 32'h3C);
    @(posedge clk);
    #1;
    drive_bit(1'b0, 1'b1);

    // Bad stop bit, release line, then a good frame clears frame_err
    send_frame(1'b0, 8'h55, 1'b1, 1'b0, 1'b0);
    drive_bit(1'b0, 1'b1);
    drive_bit(1'b0, 1'b1);
    @(negedge clk);
    chk("A_frame_err_held", 32'(ifa.frame_err), 32'd1);
    @(posedge clk);
    #1;
    send_frame(1'b0, 8'h12, 1'b1, 1'b1, 1'b0);
    drive_bit(1'b0, 1'b1);

    // Back-to-back frames on A
    send_frame(1'b0, 8'h01, 1'b0, 1'b1, 1'b0);
    send_frame(1'b0, 8'hFF, 1'b1, 1'b1, 1'b0);
    send_frame(1'b0, 8'h80, 1'b0, 1'b1, 1'b0);
    drive_bit(1'b0, 1'b1);

    // Break: line held low; one frame with data 00, framing error, no re-trigger
    e.d = 8'h00; e.pe = 1'b1; e.fe = 1'b1; e.t0 = cyc; e.lat = 1'b0;
    qa.push_back(e);
    for (int i = 0; i < 14; i++) drive_bit(1'b0, 1'b0);
    @(negedge clk);
    chk("A_break_no_retrigger_busy", 32'(ifa.busy), 32'd0);
    chk("A_break_frame_err", 32'(ifa.frame_err), 32'd1);
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) drive_bit(1'b0, 1'b1);

    // Reset during data bit 4 of C3; nothing queued for the aborted frame
    d = 8'hC3;
    drive_bit(1'b0, 1'b0);
    for (int i = 0; i < 4; i++) drive_bit(1'b0, d[i]);
    rxa = d[4];
    repeat (BRA / 2) @(posedge clk);
    #1 rst_n = 1'b0;
    @(negedge clk);
    chk_outputs_reset("A_midframe");
    rxa = 1'b1;
    @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (2 * BRA) @(posedge clk);
    #1;
    send_frame(1'b0, 8'hC3, 1'b1, 1'b1, 1'b0);
    drive_bit(1'b0, 1'b1);

    // Back-to-back frames on B (BR=4, no parity)
    send_frame(1'b1, 8'h01, 1'b0, 1'b1, 1'b0);
    send_frame(1'b1, 8'hFF, 1'b0, 1'b1, 1'b0);
    send_frame(1'b1, 8'h80, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) drive_bit(1'b1, 1'b1);

    // Every queued frame must have been delivered
    for (int i = 0; i < 200 && (qa.size() > 0 || qb.size() > 0); i++) @(posedge clk);
    chk("A_scoreboard_drained", 32'(qa.size()), 32'd0);
    chk("B_scoreboard_drained", 32'(qb.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
